// File: rtl/cfa_pkg.sv
// cfa_pkg: shared mode codes, weight table and width/saturation helpers for the CFA gradient engine
package cfa_pkg;
    localparam logic [1:0] MODE_HV  = 2'd0;
    localparam logic [1:0] MODE_CTR = 2'd1;
    localparam logic [1:0] MODE_BOX = 2'd2;
    localparam logic [1:0] MODE_ALT = 2'd3;
    function automatic int es_w(input int pw, input int taps);
        return pw + $clog2(taps);
    endfunction
    function automatic int gs_w(input int pw, input int taps);
        return es_w(pw, taps) + 4;
    endfunction
    // MODE_ALT deliberately aliases MODE_HV
    function automatic logic signed [2:0] weight(input logic [1:0] mode, input int idx);
        logic signed [2:0] w_hv, w_ctr;
        w_hv  = idx == 0 ? 3'sd1 : idx == 1 ? -3'sd2 : idx == 3 ? 3'sd2 : idx == 4 ? -3'sd1 : 3'sd0;
        w_ctr = (idx == 0 || idx == 4) ? 3'sd1 : idx == 2 ? -3'sd2 : 3'sd0;
        return mode == MODE_BOX ? 3'sd1 : mode == MODE_CTR ? w_ctr : (mode == MODE_ALT ? w_hv : w_hv);
    endfunction
    // true when mag does not fit in w unsigned bits
    function automatic logic clips(input logic [63:0] mag, input int w);
        return (mag >> w) != 64'd0;
    endfunction
endpackage

// File: rtl/cfa_entry_sum.sv
// cfa_entry_sum: combinational balanced adder tree summing TAPS unsigned pixels
//   pix_i  TAPS*PIXEL_W  tap j at [j*PIXEL_W +: PIXEL_W]
//   sum_o  ES_W          unsigned sum, cannot overflow
module cfa_entry_sum
    import cfa_pkg::*;
#(
    parameter int PIXEL_W = 12,
    parameter int TAPS    = 5
) (
    input  logic [TAPS*PIXEL_W-1:0]        pix_i,
    output logic [es_w(PIXEL_W, TAPS)-1:0] sum_o
);
    localparam int ES_W = es_w(PIXEL_W, TAPS);
    localparam int LV   = $clog2(TAPS);
    localparam int N    = 1 << LV;
    // tree padded to a power of two with zero leaves
    for (genvar l = 0; l <= LV; l++) begin : lv
        logic [ES_W-1:0] s [N >> l];
        for (genvar k = 0; k < (N >> l); k++) begin : nd
            if (l == 0) begin : leaf
                if (k < TAPS) begin : tap
                    assign s[k] = ES_W'(pix_i[k*PIXEL_W +: PIXEL_W]);
                end else begin : pad
                    assign s[k] = '0;
                end
            end else begin : add
                assign s[k] = lv[l-1].s[2*k] + lv[l-1].s[2*k+1];
            end
        end
    end
    assign sum_o = lv[LV].s[0];
endmodule

// File: rtl/cfa_grad_pipe.sv
// cfa_grad_pipe: 3-stage valid/ready gradient engine with per-frame max and handoff count
//   start             clears grad_max/out_cnt (coincident handoff counts as the first)
//   in_valid/in_ready window handshake; pix_in entry i tap j at [(i*TAPS+j)*PIXEL_W +: PIXEL_W]
//   mode              weight set sampled with the window
//   out_valid/out_ready result handshake; e_out, grad_out, grad_sat aligned with out_valid
//   grad_max, out_cnt running stats over handed-off results
module cfa_grad_pipe
    import cfa_pkg::*;
#(
    parameter int PIXEL_W = 12,
    parameter int TAPS    = 5,
    parameter int OUT_W   = PIXEL_W + 5,
    parameter int CNT_W   = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [5*TAPS*PIXEL_W-1:0]        pix_in,
    input  logic [1:0]                       mode,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [5*es_w(PIXEL_W, TAPS)-1:0] e_out,
    output logic [OUT_W-1:0]                 grad_out,
    output logic                             grad_sat,
    output logic [OUT_W-1:0]                 grad_max,
    output logic [CNT_W-1:0]                 out_cnt
);
    localparam int ES_W = es_w(PIXEL_W, TAPS);
    localparam int GS_W = gs_w(PIXEL_W, TAPS);
    logic                     en, hs;
    logic                     v1_q, v2_q, v3_q;
    logic [5*ES_W-1:0]        es_d, e1_q, e2_q, e3_q;
    logic [1:0]               mode1_q;
    logic signed [GS_W-1:0]   gs_d, gs2_q, ext, mag;
    logic signed [2:0]        w;
    logic [GS_W-1:0]          abs_d;
    logic                     sat_d, sat_q;
    logic [OUT_W-1:0]         grad_d, grad_q, max_d, max_q;
    logic [CNT_W-1:0]         cnt_d, cnt_q;
    assign en       = !v3_q || out_ready;
    assign hs       = v3_q && out_ready;
    assign in_ready = en;
    for (genvar i = 0; i < 5; i++) begin : ent
        cfa_entry_sum #(.PIXEL_W(PIXEL_W), .TAPS(TAPS)) u_sum (
            .pix_i(pix_in[i*TAPS*PIXEL_W +: TAPS*PIXEL_W]),
            .sum_o(es_d[i*ES_W +: ES_W])
        );
    end
    // weights are limited to 0, +-1, +-2 so each term is a shift plus add/subtract
    always_comb begin
        gs_d = '0;
        w    = '0;
        ext  = '0;
        mag  = '0;
        for (int i = 0; i < 5; i++) begin
            w    = weight(mode1_q, i);
            ext  = $signed({4'b0, e1_q[i*ES_W +: ES_W]});
            mag  = (w == 3'sd0) ? '0 : (w == 3'sd2 || w == -3'sd2) ? ext <<< 1 : ext;
            gs_d = w[2] ? gs_d - mag : gs_d + mag;
        end
    end
    always_comb begin
        abs_d  = gs2_q[GS_W-1] ? GS_W'(-gs2_q) : GS_W'(gs2_q);
        sat_d  = clips(64'(abs_d), OUT_W);
        grad_d = sat_d ? '1 : OUT_W'(abs_d);
        max_d  = start ? (hs ? grad_q : '0) : (hs && grad_q > max_q) ? grad_q : max_q;
        cnt_d  = start ? CNT_W'(hs) : (hs && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            e1_q    <= '0;
            e2_q    <= '0;
            e3_q    <= '0;
            mode1_q <= '0;
            gs2_q   <= '0;
            grad_q  <= '0;
            sat_q   <= 1'b0;
            max_q   <= '0;
            cnt_q   <= '0;
        end else begin
            if (en) begin
                v1_q    <= in_valid;
                e1_q    <= es_d;
                mode1_q <= mode;
                v2_q    <= v1_q;
                e2_q    <= e1_q;
                gs2_q   <= gs_d;
                v3_q    <= v2_q;
                e3_q    <= e2_q;
                grad_q  <= grad_d;
                sat_q   <= sat_d;
            end
            max_q <= max_d;
            cnt_q <= cnt_d;
        end
    end
    assign out_valid = v3_q;
    assign e_out     = e3_q;
    assign grad_out  = grad_q;
    assign grad_sat  = sat_q;
    assign grad_max  = max_q;
    assign out_cnt   = cnt_q;
endmodule
